// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the serial instruction loader.
// Holds the session FSM encoding and the framing sizes of the byte stream.
package instruction_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERROR
    } loader_state_e;

    localparam int LOADER_HEADER_BYTES = 4;
    localparam int LOADER_WORD_BYTES   = 4;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Little-endian byte-lane shift register: four pushes build one 32-bit word.
// The loader reuses it for both the word-count header and every payload word.
module word_assembler
    import instruction_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [31:0] next_word_o,
    output logic        last_o,
    output logic        full_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  lane_q, lane_d;
    logic        full_q, full_d;

    // Newest byte enters at the top so the first byte ends up in bits 7:0.
    assign next_word_o = {byte_i, word_q[31:8]};
    assign last_o      = push_i && (lane_q == 2'(LOADER_WORD_BYTES - 1));

    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        full_d = full_q;
        if (clear_i) begin
            word_d = '0;
            lane_d = '0;
            full_d = 1'b0;
        end else if (push_i) begin
            word_d = next_word_o;
            lane_d = lane_q + 2'd1;
            full_d = last_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            lane_q <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
            full_q <= full_d;
        end
    end

    assign word_o = word_q;
    assign full_o = full_q;

endmodule

// File: rtl/instruction_loader.sv
// Serial boot loader: takes a little-endian word count then that many words
// from a valid/ready byte stream and writes them to instruction memory.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned MEMORY_WORDS = 256,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        loader_start,
    input  logic        loader_byte_valid,
    input  logic [7:0]  loader_byte_data,
    output logic        loader_byte_ready,
    output logic        instruction_memory_write_enable,
    output logic [31:0] instruction_memory_access_address,
    output logic [31:0] instruction_memory_write_data,
    output logic        cpu_hold,
    output logic        loader_busy,
    output logic        loader_done,
    output logic        loader_error
);

    loader_state_e state_q, state_d;
    logic [31:0]   word_idx_q, word_idx_d;
    logic [31:0]   count_q, count_d;

    logic          accept, start_ok;
    logic [31:0]   asm_word, asm_next;
    logic          asm_last, asm_full;

    assign accept   = loader_byte_valid && loader_byte_ready;
    assign start_ok = loader_start &&
                      (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

    word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (start_ok),
        .push_i      (accept),
        .byte_i      (loader_byte_data),
        .word_o      (asm_word),
        .next_word_o (asm_next),
        .last_o      (asm_last),
        .full_o      (asm_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_idx_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
        end
    end

    // The count is judged on the fly from the 4th header byte so DONE/ERROR
    // land in the very next cycle.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_ok) begin
                    state_d    = S_COUNT;
                    word_idx_d = '0;
                    count_d    = '0;
                end
            end
            S_COUNT: begin
                if (asm_last) begin
                    count_d = asm_next;
                    if (asm_next == 32'd0)                    state_d = S_DONE;
                    else if (asm_next > 32'(MEMORY_WORDS))    state_d = S_ERROR;
                    else                                      state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (asm_last) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (word_idx_q + 32'd1 == count_q) begin
                    state_d = S_DONE;
                end else begin
                    word_idx_d = word_idx_q + 32'd1;
                    state_d    = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        loader_byte_ready                 = (state_q == S_COUNT) || (state_q == S_LOAD);
        instruction_memory_write_enable   = 1'b0;
        instruction_memory_access_address = '0;
        instruction_memory_write_data     = '0;
        loader_busy  = (state_q == S_COUNT) || (state_q == S_LOAD) || (state_q == S_WRITE);
        loader_done  = (state_q == S_DONE);
        loader_error = (state_q == S_ERROR);
        cpu_hold     = (state_q != S_DONE);
        if (state_q == S_WRITE && asm_full) begin
            instruction_memory_write_enable   = 1'b1;
            instruction_memory_access_address = BASE_ADDRESS + (word_idx_q << 2);
            instruction_memory_write_data     = asm_word;
        end
    end

endmodule
